// File: rtl/keypad_debouncer_pkg.sv
// Shared types and constants for the keypad debounce responder.
// Imported by the interface, the synchronizer and the debouncer top.
package keypad_pkg;

    typedef enum logic [1:0] {
        DB_IDLE  = 2'b00,
        DB_COUNT = 2'b01,
        DB_HOLD  = 2'b10
    } dbstate_t;

    localparam int DB_CYCLES_DEFAULT = 240000;
    localparam int KEY_COLS          = 4;

endpackage

// File: rtl/keypad_debouncer_if.sv
// Handshake between the keypad control FSM (master) and the debouncer (slave).
// The raw column pins are not part of this bundle; they enter the debouncer directly.
interface keypad_debouncer_if;
    import keypad_pkg::*;

    logic                dbreq;
    logic [KEY_COLS-1:0] activeCol;
    logic                dbhigh;
    logic                dblow;
    logic [1:0]          debugState;

    modport master (
        output dbreq, activeCol,
        input  dbhigh, dblow, debugState
    );

    modport slave (
        input  dbreq, activeCol,
        output dbhigh, dblow, debugState
    );

endinterface

// File: rtl/keypad_debouncer_sync_ff.sv
// Multi-stage flop synchronizer, one independent chain per bit.
// q lags d by STAGES clock edges; cleared by reset only.
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [STAGES-1:0] chain_reg;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg[0] <= d[gi];
                    for (int i = 1; i < STAGES; i++) begin
                        chain_reg[i] <= chain_reg[i-1];
                    end
                end
            end

            assign q[gi] = chain_reg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/keypad_debouncer.sv
// Debounce responder: qualifies the selected keypad column as stably pressed
// or released while the control FSM holds dbreq, answering with one-cycle pulses.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [KEY_COLS-1:0] col,
    keypad_debouncer_if.slave   db
);

    localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [KEY_COLS-1:0] col_s;
    logic                sample;

    dbstate_t            state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                lvl_reg;
    logic                dbhigh_reg;
    logic                dblow_reg;

    sync_ff #(
        .WIDTH  (KEY_COLS),
        .STAGES (SYNC_STAGES)
    ) u_col_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (col),
        .q    (col_s)
    );

    // Multi-hot activeCol ORs its columns; an empty selection reads as released.
    assign sample = |(col_s & db.activeCol);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= DB_IDLE;
            cnt_reg    <= '0;
            lvl_reg    <= 1'b0;
            dbhigh_reg <= 1'b0;
            dblow_reg  <= 1'b0;
        end else begin
            dbhigh_reg <= 1'b0;
            dblow_reg  <= 1'b0;
            case (state_reg)
                DB_IDLE: begin
                    if (db.dbreq) begin
                        state_reg <= DB_COUNT;
                        lvl_reg   <= sample;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end
                DB_COUNT: begin
                    // Dropping dbreq outranks both a level change and completion.
                    if (!db.dbreq) begin
                        state_reg <= DB_IDLE;
                        cnt_reg   <= '0;
                    end else if (sample != lvl_reg) begin
                        lvl_reg   <= sample;
                        cnt_reg   <= CNT_ONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg  <= DB_HOLD;
                        cnt_reg    <= cnt_reg + CNT_ONE;
                        dbhigh_reg <= lvl_reg;
                        dblow_reg  <= ~lvl_reg;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_ONE;
                    end
                end
                DB_HOLD: begin
                    if (!db.dbreq) begin
                        state_reg <= DB_IDLE;
                        cnt_reg   <= '0;
                    end else if (sample != lvl_reg) begin
                        state_reg <= DB_COUNT;
                        lvl_reg   <= sample;
                        cnt_reg   <= CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= DB_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign db.dbhigh     = dbhigh_reg;
    assign db.dblow      = dblow_reg;
    assign db.debugState = state_reg;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with DB_CYCLES=4: a per-cycle vector table
// followed by hand-written abort, restart-on-completion and reset-mid-count sequences.
module tb_keypad_debouncer;
    import keypad_pkg::*;

    localparam logic [3:0] P  = 4'b0100;
    localparam logic [3:0] C8 = 4'b1000;
    localparam logic [3:0] CF = 4'b1111;
    localparam logic [3:0] CC = 4'b1100;
    localparam logic [1:0] SI = 2'b00;
    localparam logic [1:0] SC = 2'b01;
    localparam logic [1:0] SH = 2'b10;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] col;

    keypad_debouncer_if u_if ();

    keypad_debouncer #(
        .DB_CYCLES   (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .col  (col),
        .db   (u_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       dbreq;
        logic [3:0] col;
        logic [3:0] ac;
        logic [1:0] st;
        logic       hi;
        logic       lo;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    function automatic void add(input logic r, input logic d, input logic [3:0] c,
                                input logic [3:0] a, input logic [1:0] st,
                                input logic hi, input logic lo, input int n);
        vec_t v;
        v.rstn = r; v.dbreq = d; v.col = c; v.ac = a; v.st = st; v.hi = hi; v.lo = lo;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        else
            passes++;
    endtask

    // Inputs are driven #1 after an edge, so they are settled at the next edge;
    // outputs are compared #1 after that edge.
    task automatic step(input logic r, input logic d, input logic [3:0] c, input logic [3:0] a,
                        input logic [1:0] st, input logic hi, input logic lo, input string tag);
        rstn = r; u_if.dbreq = d; col = c; u_if.activeCol = a;
        @(posedge clk);
        #1;
        cyc++;
        $display("%s cyc=%0d rstn=%b dbreq=%b col=%b ac=%b -> state=%b hi=%b lo=%b",
                 tag, cyc, r, d, c, a, u_if.debugState, u_if.dbhigh, u_if.dblow);
        check({tag, ".state"},  {2'b00, u_if.debugState}, {2'b00, st});
        check({tag, ".dbhigh"}, {3'b000, u_if.dbhigh},    {3'b000, hi});
        check({tag, ".dblow"},  {3'b000, u_if.dblow},     {3'b000, lo});
    endtask

    initial begin
        rstn = 1'b0; u_if.dbreq = 1'b0; col = 4'b0000; u_if.activeCol = P;

        // reset, then clean press
        add(0, 0, 4'b0000, P, SI, 0, 0, 2);
        add(1, 0, P, P, SI, 0, 0, 2);
        add(1, 1, P, P, SC, 0, 0, 3);
        add(1, 1, P, P, SH, 1, 0, 1);
        add(1, 1, P, P, SH, 0, 0, 2);
        // one-cycle dbreq drop: re-qualify held key, then release
        add(1, 0, P, P, SI, 0, 0, 1);
        add(1, 1, P, P, SC, 0, 0, 3);
        add(1, 1, P, P, SH, 1, 0, 1);
        add(1, 1, 4'b0000, P, SH, 0, 0, 2);
        add(1, 1, 4'b0000, P, SC, 0, 0, 3);
        add(1, 1, 4'b0000, P, SH, 0, 1, 1);
        add(1, 1, 4'b0000, P, SH, 0, 0, 2);
        // unselected column pressed
        add(1, 0, C8, P, SI, 0, 0, 2);
        add(1, 1, C8, P, SC, 0, 0, 3);
        add(1, 1, C8, P, SH, 0, 1, 1);
        add(1, 1, C8, P, SH, 0, 0, 1);
        // empty selection with all columns pressed
        add(1, 0, CF, 4'b0000, SI, 0, 0, 2);
        add(1, 1, CF, 4'b0000, SC, 0, 0, 3);
        add(1, 1, CF, 4'b0000, SH, 0, 1, 1);
        add(1, 1, CF, 4'b0000, SH, 0, 0, 1);
        // multi-hot selection
        add(1, 0, CF, CC, SI, 0, 0, 1);
        add(1, 1, CF, CC, SC, 0, 0, 3);
        add(1, 1, CF, CC, SH, 1, 0, 1);
        // bouncy press: sampled 1,0,1 then stable 1
        add(1, 0, 4'b0000, P, SI, 0, 0, 2);
        add(1, 0, P, P, SI, 0, 0, 1);
        add(1, 0, 4'b0000, P, SI, 0, 0, 1);
        add(1, 1, P, P, SC, 0, 0, 5);
        add(1, 1, P, P, SH, 1, 0, 1);
        add(1, 1, P, P, SH, 0, 0, 1);
        // press then release before qualification
        add(1, 0, P, P, SI, 0, 0, 2);
        add(1, 1, 4'b0000, P, SC, 0, 0, 5);
        add(1, 1, 4'b0000, P, SH, 0, 1, 1);
        add(1, 1, 4'b0000, P, SH, 0, 0, 1);

        foreach (vecs[i])
            step(vecs[i].rstn, vecs[i].dbreq, vecs[i].col, vecs[i].ac,
                 vecs[i].st, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

        // abort on the completing edge, then a full requalification
        step(1, 0, P, P, SI, 0, 0, "abort_idle");
        step(1, 0, P, P, SI, 0, 0, "abort_idle");
        for (int k = 0; k < 3; k++) step(1, 1, P, P, SC, 0, 0, "abort_cnt");
        step(1, 0, P, P, SI, 0, 0, "abort_drop");
        for (int k = 0; k < 3; k++) step(1, 1, P, P, SC, 0, 0, "abort_recnt");
        step(1, 1, P, P, SH, 1, 0, "abort_pulse");

        // level change on the completing edge restarts the count
        step(1, 0, P, P, SI, 0, 0, "restart_idle");
        step(1, 1, P, P, SC, 0, 0, "restart_c1");
        step(1, 1, 4'b0000, P, SC, 0, 0, "restart_c2");
        step(1, 1, 4'b0000, P, SC, 0, 0, "restart_c3");
        step(1, 1, 4'b0000, P, SC, 0, 0, "restart_chg");
        step(1, 1, 4'b0000, P, SC, 0, 0, "restart_c2b");
        step(1, 1, 4'b0000, P, SC, 0, 0, "restart_c3b");
        step(1, 1, 4'b0000, P, SH, 0, 1, "restart_pulse");

        // reset mid-count clears synchronizer and counter
        step(1, 0, P, P, SI, 0, 0, "rst_idle");
        step(1, 1, P, P, SC, 0, 0, "rst_cnt");
        step(1, 1, P, P, SC, 0, 0, "rst_cnt");
        step(0, 1, P, P, SI, 0, 0, "rst_assert");
        step(1, 1, P, P, SC, 0, 0, "rst_r1");
        step(1, 1, P, P, SC, 0, 0, "rst_r2");
        step(1, 1, P, P, SC, 0, 0, "rst_r3");
        step(1, 1, P, P, SC, 0, 0, "rst_r4");
        step(1, 1, P, P, SC, 0, 0, "rst_r5");
        step(1, 1, P, P, SH, 1, 0, "rst_pulse");
        step(1, 1, P, P, SH, 0, 0, "rst_hold");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/keypad_debouncer.md
Name: keypad_debouncer

Overview:
Debounce responder for the keypad control FSM. The control FSM drives dbreq high while it waits on a candidate key. This block synchronizes the raw column inputs and selects the active column. It reports a stable press on dbhigh or a stable release on dblow, each as a one-cycle pulse after DB_CYCLES consecutive equal samples. It sits between the keypad pins and the control FSM, beside the row scanner.

Parameters:
DB_CYCLES, 240000, consecutive equal samples required to declare a stable level (5 ms at 48 MHz); must be >= 2; benches override to 4
SYNC_STAGES, 2, depth of the col input synchronizer
CNT_W, $clog2(DB_CYCLES+1), derived localparam, sample counter width

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous, active-low
dbreq  input  1  debounce request from control FSM; level, held high while the FSM waits
col  input  4  raw keypad column pins, active-high, asynchronous to clk
activeCol  input  4  column under test (one-hot from control FSM; any value tolerated)
dbhigh  output  1  one-cycle pulse: selected key stable pressed
dblow  output  1  one-cycle pulse: selected key stable released
debugState  output  2  current state encoding for bring-up

Behaviour:
- Reset (rstn=0 at posedge): state=DB_IDLE, cnt=0, lvl=0, all synchronizer flops=0, dbhigh=dblow=0. No pulse can occur earlier than DB_CYCLES edges after reset release.
- Synchronizer: SYNC_STAGES flops per col bit. It always runs and is not cleared by dbreq. col_s lags col by SYNC_STAGES edges.
- Sample: s = |(col_s & activeCol), combinational. Multi-hot activeCol ORs its columns. activeCol=0 gives s=0.
- dbhigh and dblow are registered, never both high, and are high for exactly one cycle per detection.
- Default at every edge: dbhigh<=0, dblow<=0.
- DB_IDLE (debugState 00):
  - dbreq=1 -> DB_COUNT, lvl<=s, cnt<=1.
  - Otherwise stay, cnt<=0.
- DB_COUNT (01):
  - dbreq=0 -> DB_IDLE, cnt<=0, no pulse.
  - s!=lvl -> lvl<=s, cnt<=1, stay.
  - s==lvl and cnt+1==DB_CYCLES -> DB_HOLD; dbhigh<=lvl, dblow<=~lvl.
  - Otherwise cnt<=cnt+1.
- DB_HOLD (10):
  - dbreq=0 -> DB_IDLE, cnt<=0.
  - s!=lvl -> DB_COUNT, lvl<=s, cnt<=1.
  - Otherwise stay, no further pulses.
- Latency: with col_s stable from the edge where dbreq is first sampled high (E0), the pulse is high in the cycle after edge E0+DB_CYCLES-1.
- Simultaneous events: dbreq falling on the completing edge wins, giving DB_IDLE and no pulse. A level change on the completing edge restarts the count.
- Counter: never exceeds DB_CYCLES, no wrap. Unused encoding 11 -> DB_IDLE with outputs 0.
- Protocol consequence: during the control FSM's one-cycle dbreq drop (UPDATE), this block returns to DB_IDLE. It re-qualifies the held key, pulsing dbhigh (ignored by the FSM in WAIT), then pulses dblow after a stable release.
- Reset mid-count: everything cleared, no pulse.

Decomposition:
- Shared package keypad_pkg:
  - dbstate_t enum {DB_IDLE=2'b00, DB_COUNT=2'b01, DB_HOLD=2'b10}
  - constant DB_CYCLES_DEFAULT=240000
  - constant KEY_COLS=4
- One sub-module: sync_ff (parameters WIDTH, STAGES), instantiated for col.
- Counter and FSM live in keypad_debouncer.

Test Plan:
All scenarios use DB_CYCLES=4, SYNC_STAGES=2 and activeCol=4'b0100 unless noted.
- Clean press: col=4'b0100 held for 2 edges, then dbreq raised -> dbhigh high for exactly 1 cycle after the 4th sampled edge; dblow never high; state DB_HOLD.
- Bouncy press: col_s toggles 1,0,1 on the first three sampled edges, then stays 1 -> dbhigh pulses once, 4 edges after the final 0->1 transition; no dblow.
- Press-release rejection: col_s=1 for 2 edges, then 0 stable, dbreq high -> single dblow pulse 4 edges after the 1->0 change; no dbhigh.
- Full handshake: press, dbhigh, dbreq low 1 cycle, dbreq high with key held -> second dbhigh 4 edges later. Then col=0 -> dblow exactly once, 4 edges after col_s falls; no repeat while held in DB_HOLD.
- Abort: dbreq drops on the edge that would complete the count -> no pulse, state DB_IDLE, cnt=0. Also rstn=0 mid-count -> outputs 0 and the next pulse is no earlier than 4 edges after release.
- Column selection: col=4'b1000 with activeCol=4'b0100 -> s=0, dblow after 4 edges. Then activeCol=4'b0000 with col=4'b1111 -> dblow, never dbhigh.
